sparse_ws_array_db: RTL and testbench
=====================================

SPARSE_WS_ARRAY_DB -- requirements
Module: sparse_ws_array_db

Interface
REQ-001 SHALL have parameter N_ROWS, default 8, PE rows (>=1).
REQ-002 SHALL have parameter N_COLS, default 8, PE columns (>=1).
REQ-003 SHALL have parameter DATA_W, default 8, signed activation/weight width.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator width (>=2*DATA_W).
REQ-005 SHALL have: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have: wgt_valid  in  1  weight-row beat valid.
REQ-008 SHALL have: wgt_ready  out  1  shadow bank can accept a row.
REQ-009 SHALL have: wgt_row_flat  in  N_COLS*DATA_W  one weight row; column c at [c*DATA_W +: DATA_W].
REQ-010 SHALL have: wgt_swap  in  1  promote shadow bank to active.
REQ-011 SHALL have: swap_err  out  1  one-cycle pulse, swap request rejected.
REQ-012 SHALL have: act_valid, act_last  in  1 each  activation beat valid / final beat of tile.
REQ-013 SHALL have: act_ready  out  1  array accepts activation beats.
REQ-014 SHALL have: act_in_flat  in  N_ROWS*DATA_W  activations; row r at [r*DATA_W +: DATA_W].
REQ-015 SHALL have: row_mask  in  N_ROWS  per-row zero-skip; 1 = row accumulates, sampled with each beat.
REQ-016 SHALL have: acc_clr  in  1  clear all accumulators.
REQ-017 SHALL have: c_out_flat  out  N_ROWS*N_COLS*ACC_W  PE (r,c) at [(r*N_COLS+c)*ACC_W +: ACC_W]; c_valid  out  1  one-cycle result strobe.

Function
REQ-018 Weight-stationary dataflow: PE(r,c) holds active weight W[r][c]; activation a[r] and its valid/mask bits shift one column per cycle.
REQ-019 Beat accepted on edge t (act_valid && act_ready) SHALL update column c accumulators on edge t+c.
REQ-020 Accumulate rule: acc += sign_extend(a*W) (full 2*DATA_W signed product) only when carried valid=1 and carried mask bit=1; result wraps modulo 2^ACC_W.
REQ-021 Masked/invalid slots SHALL hold acc and not toggle the multiplier operand registers.
REQ-022 Shadow load: each wgt_valid && wgt_ready beat writes shadow row load_ptr, load_ptr increments; wgt_ready = 0 once N_ROWS rows loaded (shadow_full).
REQ-023 wgt_swap accepted when shadow_full and FSM in IDLE or DONE: active <= shadow in one cycle, shadow_full cleared, load_ptr <= 0; otherwise swap_err pulses and banks unchanged.
REQ-024 Shadow loading SHALL proceed concurrently with COMPUTE/DRAIN without disturbing active weights.
REQ-025 FSM states IDLE, COMPUTE, DRAIN, DONE; IDLE->COMPUTE on accepted beat without act_last; IDLE/COMPUTE->DRAIN on accepted beat with act_last (->DONE directly if N_COLS=1); DRAIN lasts N_COLS-1 cycles via counter, then DONE; DONE->IDLE after one cycle.
REQ-026 act_ready = 1 in IDLE and COMPUTE only; c_valid = 1 exactly in DONE.
REQ-027 c_out_flat reflects accumulators continuously and SHALL be stable from DONE until next acc_clr or accepted beat.
REQ-028 acc_clr honoured only in IDLE/DONE (zeros all acc next edge); ignored in COMPUTE/DRAIN; if coincident with an accepted beat in IDLE, clear wins for column 0 and that beat contributes nothing.
REQ-029 wgt_swap coincident with the N_ROWS-th weight beat SHALL be rejected (swap_err) since shadow_full not yet set.

Reset
REQ-030 On rst, asynchronously: FSM=IDLE, all acc, pipeline valid bits, both weight banks, load_ptr, drain counter = 0; outputs wgt_ready=1, act_ready=1, c_valid=0, swap_err=0, c_out_flat=0.
REQ-031 rst asserted mid-COMPUTE/DRAIN SHALL abort the tile with no c_valid pulse.

Structure
REQ-032 FSM state enum and shared constants (state width) SHALL live in the shared accelerator package.
REQ-033 One sub-module pe_db: PE with active weight register, mask/valid pass-through and accumulator; shadow bank and FSM stay in the top level.

Verification
REQ-034 Reset: after rst, c_out_flat=0, wgt_ready=1, act_ready=1, c_valid=0.
REQ-035 Load 8 rows all weights 1, swap, one beat all activations 2 with act_last, mask all 1 -> c_valid 8 cycles after accept edge, every c_out=2.
REQ-036 Same with row_mask=8'b1111_0111 -> row 3 outputs 0, others 2.
REQ-037 Send 9 weight beats without swap -> 9th not accepted, wgt_ready=0; swap during COMPUTE -> swap_err pulse, outputs unchanged.
REQ-038 Weights -128, activations -128, 3 beats -> every c_out=49152; ACC_W=16 build wraps to -16384.
REQ-039 Assert rst during DRAIN -> all outputs 0 immediately, no c_valid.

Source files
------------

// File: rtl/sparse_ws_array_db_pkg.sv
// Shared types for the weight-stationary array: control FSM states and sizing helpers.
// No logic or latency of its own; no backpressure involvement.
package sparse_ws_array_db_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sparse_ws_array_db_pe.sv
// One PE: active weight register, signed MAC into a wrapping accumulator, one-cycle forward of a/valid/mask.
// Latency 1 cycle to the next column; no backpressure, the array controller gates all inputs.
module pe_db
   import sparse_ws_array_db_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wgt_load,
   input  logic signed [DATA_W-1:0] wgt_shadow,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic                     vld_in,
   input  logic                     msk_in,
   input  logic                     clr,
   output logic signed [DATA_W-1:0] a_out,
   output logic                     vld_out,
   output logic                     msk_out,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [DATA_W-1:0]   wgt;
   logic signed [2*DATA_W-1:0] prod;
   logic                       hit;

   assign hit  = vld_in & msk_in;
   assign prod = a_in * wgt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wgt     <= '0;
         a_out   <= '0;
         vld_out <= 1'b0;
         msk_out <= 1'b0;
         acc     <= '0;
      end else begin
         if (wgt_load)
            wgt <= wgt_shadow;
         vld_out <= vld_in;
         msk_out <= msk_in;
         // Skipped slots leave the downstream operand frozen so the next multiplier sees no toggle.
         if (hit)
            a_out <= a_in;
         if (clr)
            acc <= '0;
         else if (hit)
            acc <= acc + ACC_W'(prod);
      end
   end
endmodule

// File: rtl/sparse_ws_array_db.sv
// Weight-stationary PE array with double-buffered weights and per-row zero-skip; column c lags the accept by c cycles.
// Activations stall (act_ready=0) during DRAIN/DONE; weight rows stall once the shadow bank is full.
module sparse_ws_array_db
   import sparse_ws_array_db_pkg::*;
#(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wgt_valid,
   output logic                             wgt_ready,
   input  logic [N_COLS*DATA_W-1:0]         wgt_row_flat,
   input  logic                             wgt_swap,
   output logic                             swap_err,
   input  logic                             act_valid,
   input  logic                             act_last,
   output logic                             act_ready,
   input  logic [N_ROWS*DATA_W-1:0]         act_in_flat,
   input  logic [N_ROWS-1:0]                row_mask,
   input  logic                             acc_clr,
   output logic [N_ROWS*N_COLS*ACC_W-1:0]   c_out_flat,
   output logic                             c_valid
);
   localparam int PTR_W      = cnt_w(N_ROWS);
   localparam int DCNT_W     = cnt_w(N_COLS);
   localparam int DRAIN_LAST = (N_COLS > 1) ? N_COLS - 2 : 0;

   state_t              state, state_nxt;
   logic [PTR_W-1:0]    load_ptr;
   logic                shadow_full;
   logic [DATA_W-1:0]   shadow [N_ROWS][N_COLS];
   logic [DCNT_W-1:0]   drain_cnt;
   logic                quiet, wgt_fire, act_fire, swap_ok, clr_en;

   logic signed [DATA_W-1:0] a_pipe   [N_ROWS][N_COLS+1];
   logic                     vld_pipe [N_ROWS][N_COLS+1];
   logic                     msk_pipe [N_ROWS][N_COLS+1];
   logic [N_ROWS-1:0]        unused_tail;

   assign wgt_ready = ~shadow_full;
   assign wgt_fire  = wgt_valid & wgt_ready;
   assign act_fire  = act_valid & act_ready;
   assign swap_ok   = wgt_swap & shadow_full & quiet;
   assign clr_en    = acc_clr & quiet;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_COMPUTE:
            if (act_fire)
               state_nxt = act_last ? ((N_COLS == 1) ? ST_DONE : ST_DRAIN) : ST_COMPUTE;
         ST_DRAIN:
            if (drain_cnt == DCNT_W'(DRAIN_LAST))
               state_nxt = ST_DONE;
         ST_DONE:
            state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      act_ready = 1'b0;
      c_valid   = 1'b0;
      quiet     = 1'b0;
      unique case (state)
         ST_IDLE:    begin act_ready = 1'b1; quiet = 1'b1; end
         ST_COMPUTE: act_ready = 1'b1;
         ST_DONE:    begin c_valid = 1'b1; quiet = 1'b1; end
         default:    ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drain_cnt <= '0;
      else if (state != ST_DRAIN)
         drain_cnt <= '0;
      else
         drain_cnt <= drain_cnt + 1'b1;
   end

   // Shadow rows fill in order; the swap resets the fill pointer for the next set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_ptr    <= '0;
         shadow_full <= 1'b0;
         for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
               shadow[r][c] <= '0;
      end else if (swap_ok) begin
         load_ptr    <= '0;
         shadow_full <= 1'b0;
      end else if (wgt_fire) begin
         for (int c = 0; c < N_COLS; c++)
            shadow[load_ptr][c] <= wgt_row_flat[c*DATA_W +: DATA_W];
         if (load_ptr == PTR_W'(N_ROWS - 1)) begin
            load_ptr    <= '0;
            shadow_full <= 1'b1;
         end else begin
            load_ptr <= load_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         swap_err <= 1'b0;
      else
         swap_err <= wgt_swap & ~swap_ok;
   end

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      assign a_pipe[r][0]   = act_in_flat[r*DATA_W +: DATA_W];
      assign vld_pipe[r][0] = act_fire;
      assign msk_pipe[r][0] = row_mask[r];
      assign unused_tail[r] = ^{a_pipe[r][N_COLS], vld_pipe[r][N_COLS], msk_pipe[r][N_COLS]};

      for (genvar c = 0; c < N_COLS; c++) begin : g_col
         pe_db #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk        (clk),
            .rst        (rst),
            .wgt_load   (swap_ok),
            .wgt_shadow (shadow[r][c]),
            .a_in       (a_pipe[r][c]),
            .vld_in     (vld_pipe[r][c]),
            .msk_in     (msk_pipe[r][c]),
            .clr        (clr_en),
            .a_out      (a_pipe[r][c+1]),
            .vld_out    (vld_pipe[r][c+1]),
            .msk_out    (msk_pipe[r][c+1]),
            .acc        (c_out_flat[(r*N_COLS+c)*ACC_W +: ACC_W])
         );
      end
   end
endmodule

// File: tb/tb_sparse_ws_array_db.sv
// Directed bench for sparse_ws_array_db: spec-level model of tiles/banks plus literal spot checks.
// Runs a 32-bit and a 16-bit accumulator build side by side on the same stimulus.
module tb_sparse_ws_array_db;
   localparam int NR = 8;
   localparam int NC = 8;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   logic wgt_valid, wgt_swap, act_valid, act_last, acc_clr;
   logic [NC*DW-1:0] wgt_row_flat;
   logic [NR*DW-1:0] act_in_flat;
   logic [NR-1:0]    row_mask;
   logic wgt_ready, swap_err, act_ready, c_valid;
   logic wgt_ready16, swap_err16, act_ready16, c_valid16;
   logic [NR*NC*32-1:0] c_out_flat;
   logic [NR*NC*16-1:0] c_out16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sparse_ws_array_db #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
      .wgt_row_flat(wgt_row_flat), .wgt_swap(wgt_swap), .swap_err(swap_err),
      .act_valid(act_valid), .act_last(act_last), .act_ready(act_ready),
      .act_in_flat(act_in_flat), .row_mask(row_mask), .acc_clr(acc_clr),
      .c_out_flat(c_out_flat), .c_valid(c_valid));

   sparse_ws_array_db #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(16)) dut16 (
      .clk(clk), .rst(rst), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready16),
      .wgt_row_flat(wgt_row_flat), .wgt_swap(wgt_swap), .swap_err(swap_err16),
      .act_valid(act_valid), .act_last(act_last), .act_ready(act_ready16),
      .act_in_flat(act_in_flat), .row_mask(row_mask), .acc_clr(acc_clr),
      .c_out_flat(c_out16), .c_valid(c_valid16));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm,
                  $signed(act), act, $signed(exp), exp);
      end
   endtask

   function automatic logic [31:0] o32(input int r, input int c);
      return c_out_flat[(r*NC+c)*32 +: 32];
   endfunction

   function automatic logic [15:0] o16(input int r, input int c);
      return c_out16[(r*NC+c)*16 +: 16];
   endfunction

   // lane i gets base + step*i, truncated to DW bits
   function automatic logic [NR*DW-1:0] lin(input int base, input int step);
      logic [NR*DW-1:0] v;
      int x;
      for (int i = 0; i < NR; i++) begin
         x = base + step * i;
         v[i*DW +: DW] = x[DW-1:0];
      end
      return v;
   endfunction

   function automatic int sx(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   // ---------------- behavioural model ----------------
   int     w_act [NR][NC];
   int     w_sh  [NR][NC];
   longint acc_m [NR][NC];
   int     rows_m, edge_n, drain_from, done_at, last_acc;
   bit     tile_open, exp_swap_err;

   always @(posedge clk or posedge rst) begin
      bit in_done, in_drain, idle_or_done, rdy, fire, clr, sw_ok;
      if (rst) begin
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
               w_act[r][c] = 0; w_sh[r][c] = 0; acc_m[r][c] = 0;
            end
         rows_m = 0; edge_n = 0; drain_from = -1000; done_at = -1000; last_acc = -1000;
         tile_open = 1'b0; exp_swap_err = 1'b0;
      end else begin
         edge_n++;
         in_done      = (done_at == edge_n - 1);
         in_drain     = (drain_from <= edge_n - 1) && (edge_n - 1 < done_at);
         idle_or_done = !tile_open && !in_drain;
         rdy          = tile_open || (idle_or_done && !in_done);
         fire         = act_valid && rdy;
         clr          = acc_clr && idle_or_done;
         sw_ok        = wgt_swap && (rows_m == NR) && idle_or_done;
         exp_swap_err = wgt_swap && !sw_ok;
         if (clr)
            for (int r = 0; r < NR; r++)
               for (int c = 0; c < NC; c++) acc_m[r][c] = 0;
         if (fire) begin
            for (int r = 0; r < NR; r++)
               for (int c = 0; c < NC; c++)
                  if (row_mask[r] && !(clr && c == 0))
                     acc_m[r][c] += longint'(sx(act_in_flat[r*DW +: DW]) * w_act[r][c]);
            last_acc = edge_n;
            if (act_last) begin
               tile_open  = 1'b0;
               drain_from = edge_n;
               done_at    = edge_n + NC - 1;
            end else begin
               tile_open = 1'b1;
            end
         end
         if (sw_ok) begin
            w_act  = w_sh;
            rows_m = 0;
         end else if (wgt_valid && rows_m < NR) begin
            for (int c = 0; c < NC; c++) w_sh[rows_m][c] = sx(wgt_row_flat[c*DW +: DW]);
            rows_m++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit     exp_cv, exp_ar;
      int     bad_i, idx;
      longint e;
      logic [31:0] e32;
      logic [15:0] e16;
      if (!rst) begin
         exp_cv = (done_at == edge_n);
         exp_ar = !((drain_from <= edge_n) && (edge_n <= done_at));
         check("c_valid", c_valid, exp_cv);
         check("c_valid16", c_valid16, exp_cv);
         check("act_ready", act_ready, exp_ar);
         check("act_ready16", act_ready16, exp_ar);
         check("wgt_ready", wgt_ready, rows_m < NR);
         check("wgt_ready16", wgt_ready16, rows_m < NR);
         check("swap_err", swap_err, exp_swap_err);
         check("swap_err16", swap_err16, exp_swap_err);
         if (edge_n >= last_acc + NC - 1) begin
            bad_i = -1;
            for (int r = 0; r < NR; r++)
               for (int c = 0; c < NC; c++) begin
                  e = acc_m[r][c]; e32 = e[31:0];
                  if (o32(r, c) !== e32 && bad_i < 0) bad_i = r*NC + c;
               end
            idx = (bad_i < 0) ? 0 : bad_i;
            e = acc_m[idx/NC][idx%NC]; e32 = e[31:0];
            check("c_out", $signed(o32(idx/NC, idx%NC)), $signed(e32));
            bad_i = -1;
            for (int r = 0; r < NR; r++)
               for (int c = 0; c < NC; c++) begin
                  e = acc_m[r][c]; e16 = e[15:0];
                  if (o16(r, c) !== e16 && bad_i < 0) bad_i = r*NC + c;
               end
            idx = (bad_i < 0) ? 0 : bad_i;
            e = acc_m[idx/NC][idx%NC]; e16 = e[15:0];
            check("c_out16", $signed(o16(idx/NC, idx%NC)), $signed(e16));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic load_row(input logic [NC*DW-1:0] row);
      wgt_valid = 1'b1; wgt_row_flat = row;
      @(negedge clk);
      wgt_valid = 1'b0;
   endtask

   task automatic swap();
      wgt_swap = 1'b1;
      @(negedge clk);
      wgt_swap = 1'b0;
   endtask

   task automatic pulse_clr();
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
   endtask

   task automatic beat(input logic [NR*DW-1:0] a, input logic [NR-1:0] m);
      act_valid = 1'b1; act_in_flat = a; row_mask = m; act_last = 1'b0;
      @(negedge clk);
      act_valid = 1'b0;
   endtask

   // k = index of the negedge (after the accept edge) at which c_valid is seen
   task automatic run_last(input logic [NR*DW-1:0] a, input logic [NR-1:0] m, output int k);
      act_valid = 1'b1; act_in_flat = a; row_mask = m; act_last = 1'b1;
      @(negedge clk);
      act_valid = 1'b0; act_last = 1'b0; acc_clr = 1'b0;
      k = 1;
      while (!c_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int k, bad;
      rst = 1'b1; wgt_valid = 1'b0; wgt_swap = 1'b0; act_valid = 1'b0; act_last = 1'b0;
      acc_clr = 1'b0; wgt_row_flat = '0; act_in_flat = '0; row_mask = '0;
      repeat (3) @(negedge clk);
      check("rst_c_out", c_out_flat, 64'd0);
      check("rst_wgt_ready", wgt_ready, 1);
      check("rst_act_ready", act_ready, 1);
      check("rst_c_valid", c_valid, 0);
      check("rst_swap_err", swap_err, 0);
      rst = 1'b0;
      @(negedge clk);

      // all-ones weights, activations 2
      for (int r = 0; r < NR; r++) load_row(lin(1, 0));
      check("full_wgt_ready", wgt_ready, 0);
      swap();
      check("swap_ok_err", swap_err, 0);
      run_last(lin(2, 0), 8'hFF, k);
      check("latency_a", k, 8);
      bad = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) if (o32(r, c) !== 32'd2) bad++;
      check("all_twos", bad, 0);

      // row 3 masked off
      pulse_clr();
      run_last(lin(2, 0), 8'b1111_0111, k);
      check("latency_b", k, 8);
      check("mask_r3c0", $signed(o32(3, 0)), 0);
      check("mask_r3c7", $signed(o32(3, 7)), 0);
      check("mask_r2c5", $signed(o32(2, 5)), 2);

      // 9th row refused; swap during COMPUTE rejected
      pulse_clr();
      for (int r = 0; r < NR; r++) load_row(lin(3*r, -5));
      load_row(lin(7, 0));
      check("ninth_wgt_ready", wgt_ready, 0);
      beat(lin(1, 1), 8'hFF);
      swap();
      check("swap_busy_err", swap_err, 1);
      beat(lin(-3, 0), 8'h0F);
      run_last(lin(5, 0), 8'hF0, k);
      check("latency_c", k, 8);
      check("old_w_r0c4", $signed(o32(0, 4)), -2);
      check("old_w_r7c7", $signed(o32(7, 7)), 13);
      swap();
      check("swap_done_err", swap_err, 0);
      pulse_clr();
      run_last(lin(-4, 1), 8'hFF, k);
      check("pat_r0c1", $signed(o32(0, 1)), 20);
      check("pat_r2c1", $signed(o32(2, 1)), -2);
      pulse_clr();
      beat(lin(7, -3), 8'hA5);
      beat(lin(-100, 25), 8'h3C);
      run_last(lin(120, -33), 8'hFF, k);
      check("latency_d", k, 8);

      // -128 * -128 three times
      pulse_clr();
      for (int r = 0; r < NR; r++) load_row(lin(-128, 0));
      swap();
      beat(lin(-128, 0), 8'hFF);
      beat(lin(-128, 0), 8'hFF);
      run_last(lin(-128, 0), 8'hFF, k);
      bad = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            if (o32(r, c) !== 32'd49152) bad++;
            if (o16(r, c) !== 16'hC000) bad++;
         end
      check("wrap_all", bad, 0);
      check("wrap16_r5c6", $signed(o16(5, 6)), -16384);

      // clear coincident with a beat in IDLE: column 0 loses that beat
      @(negedge clk);
      acc_clr = 1'b1;
      run_last(lin(1, 0), 8'hFF, k);
      check("clrbeat_c0", $signed(o32(0, 0)), 0);
      check("clrbeat_c1", $signed(o32(0, 1)), -128);
      check("clrbeat16_c1", $signed(o16(4, 1)), -128);

      // swap with the final weight row is too early
      for (int r = 0; r < NR - 1; r++) load_row(lin(2, 0));
      wgt_swap = 1'b1;
      load_row(lin(2, 0));
      wgt_swap = 1'b0;
      check("swap_early_err", swap_err, 1);
      swap();
      check("swap_late_err", swap_err, 0);

      // reset in DRAIN
      act_valid = 1'b1; act_in_flat = lin(3, 0); row_mask = 8'hFF; act_last = 1'b1;
      @(negedge clk);
      act_valid = 1'b0; act_last = 1'b0;
      @(negedge clk);
      check("pre_rst_c0", $signed(o32(0, 0)), 6);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_c_out", c_out_flat, 64'd0);
      check("mid_rst_c_out16", c_out16, 64'd0);
      check("mid_rst_c_valid", c_valid, 0);
      check("mid_rst_act_ready", act_ready, 1);
      check("mid_rst_wgt_ready", wgt_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (c_valid !== 1'b0) bad++;
      end
      check("no_cvalid_after_abort", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
